pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-PC controller for the fetch stage. Owns the architectural PC register and
//   chooses each cycle between: hold (stall), sequential pc+STEP, branch redirect,
//   interrupt entry, return-from-interrupt and halt. Sits between the
//   ALU/branch unit and instruction memory. Exports fetch-valid and interrupt handshakes.
// PARAMETERS
//   RESET_PC   32'h20  PC value loaded by reset
//   PC_STEP    32'h2   sequential increment (16-bit instruction words)
//   INT_VECTOR 32'h0   handler address loaded on interrupt entry
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   stall        in   1   hold PC this cycle (pipeline hazard)
//   branchTaken  in   1   redirect request from branch unit
//   branchTarget in   32  redirect address (aluOut), used unmodified
//   intReq       in   1   level interrupt request, held until intAck
//   retInt       in   1   return-from-interrupt (RTI decoded)
//   haltReq      in   1   HLT decoded
//   pc           out  32  current fetch address
//   pcValid      out  1   1 = instruction at pc is to be fetched/issued
//   intAck       out  1   1-cycle pulse on interrupt entry
//   epc          out  32  saved return address
//   inIsr        out  1   1 while executing a handler (masks intReq)
//   state        out  2   FSM state, for debug
// BEHAVIOUR
// - Reset (async, any time incl. mid-ISR): pc=RESET_PC, epc=0, inIsr=0, intAck=0,
//   pcValid=0, state=BOOT. All registers update only on posedge clk otherwise.
// - States: BOOT=0, RUN=1, INTE=2, HALT=3.
// - BOOT: one cycle; pc holds RESET_PC; next state RUN. pcValid=0.
// - RUN (pcValid=1). Per-cycle priority, highest first:
//   1 stall=1          -> pc, epc, state held. All other inputs ignored this cycle.
//   2 retInt & inIsr   -> pc<=epc; inIsr<=0.
//   3 intReq & !inIsr  -> epc<=(branchTaken ? branchTarget : pc+PC_STEP);
//                         pc<=INT_VECTOR; inIsr<=1; state<=INTE.
//   4 branchTaken      -> pc<=branchTarget.
//   5 haltReq          -> pc<=pc+PC_STEP; state<=HALT.
//   6 otherwise        -> pc<=pc+PC_STEP.
//   retInt with inIsr=0 is treated as a no-op, so rule 3 onward applies.
// - INTE: one cycle; intAck=1, pcValid=0 (bubble); pc holds INT_VECTOR; next RUN.
//   intAck is registered: high exactly in the INTE cycle, else 0.
// - HALT: pcValid=0; pc held (points past HLT). Exit only via intReq & !inIsr:
//   epc<=pc, pc<=INT_VECTOR, inIsr<=1, next INTE. stall/branch/halt ignored.
//   HALT with inIsr=1 is terminal until reset.
// - Arithmetic: pc+PC_STEP is 32-bit modulo; 32'hFFFFFFFE+2 wraps to 0.
// - pcValid is combinational from state: (state==RUN).
// - No nested interrupts: intReq is ignored while inIsr=1 and remains pending.
// TESTING
//   1 reset high 3 cycles, release -> BOOT pc=0x20 pcValid=0; next RUN; then 0x22,0x24.
//   2 at pc=0x24: branchTaken=1, target=0x100 -> next pc=0x100; stall=1 same cycle
//     instead -> pc stays 0x24 and the branch is dropped.
//   3 at pc=0x30: intReq=1 -> epc=0x32, pc=0x0, INTE with intAck=1 for 1 cycle,
//     then RUN 0x0,0x2; retInt=1 -> pc=0x32, inIsr=0.
//   4 intReq and branchTaken(0x200) in the same cycle -> epc=0x200, pc=0x0;
//     intReq during inIsr=1 -> no intAck until after retInt.
//   5 haltReq at pc=0x40 -> HALT, pc=0x42, pcValid=0 indefinitely; intReq -> epc=0x42,
//     INTE, RUN at 0x0.
//   6 pc=0xFFFFFFFE sequential -> 0x0; async reset asserted mid-INTE -> immediate
//     pc=0x20, inIsr=0, intAck=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: owns the PC and picks hold, sequential,
// branch, interrupt entry, return-from-interrupt or halt each cycle.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h20,
  parameter logic [31:0] PC_STEP    = 32'h2,
  parameter logic [31:0] INT_VECTOR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        intReq,
  input  logic        retInt,
  input  logic        haltReq,
  output logic [31:0] pc,
  output logic        pcValid,
  output logic        intAck,
  output logic [31:0] epc,
  output logic        inIsr,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    INTE = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        in_isr_q, in_isr_d;
  logic        int_ack_q;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + PC_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      epc_q     <= 32'h0;
      in_isr_q  <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      in_isr_q  <= in_isr_d;
      int_ack_q <= (state_d == INTE);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_isr_d = in_isr_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (retInt && in_isr_q) begin
          pc_d     = epc_q;
          in_isr_d = 1'b0;
        end else if (intReq && !in_isr_q) begin
          // Return address is where execution would have gone this cycle.
          epc_d    = branchTaken ? branchTarget : pc_inc;
          pc_d     = INT_VECTOR;
          in_isr_d = 1'b1;
          state_d  = INTE;
        end else if (branchTaken) begin
          pc_d = branchTarget;
        end else if (haltReq) begin
          pc_d    = pc_inc;
          state_d = HALT;
        end else begin
          pc_d = pc_inc;
        end
      end
      INTE: state_d = RUN;
      HALT: begin
        if (intReq && !in_isr_q) begin
          epc_d    = pc_q;
          pc_d     = INT_VECTOR;
          in_isr_d = 1'b1;
          state_d  = INTE;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc      = pc_q;
  assign pcValid = (state_q == RUN);
  assign intAck  = int_ack_q;
  assign epc     = epc_q;
  assign inIsr   = in_isr_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: a stimulus process pushes the
// reference model's expected outputs per cycle; a monitor pops and compares.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h20;
  localparam logic [31:0] STEP   = 32'h2;
  localparam logic [31:0] VEC    = 32'h0;
  localparam int M_BOOT = 0, M_RUN = 1, M_INTE = 2, M_HALT = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        ack;
    logic [31:0] epc;
    logic        isr;
    logic [1:0]  st;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, branchTaken = 1'b0, intReq = 1'b0, retInt = 1'b0, haltReq = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic [31:0] pc, epc;
  logic        pcValid, intAck, inIsr;
  logic [1:0]  state;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .intReq(intReq), .retInt(retInt), .haltReq(haltReq),
    .pc(pc), .pcValid(pcValid), .intAck(intAck), .epc(epc), .inIsr(inIsr), .state(state)
  );

  always #5 clk = ~clk;

  obs_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: architectural view of the sequencer.
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_isr;
  logic        pend;

  function automatic obs_t model_view();
    obs_t o;
    o.pc  = m_pc;
    o.vld = (m_mode == M_RUN);
    o.ack = (m_mode == M_INTE);
    o.epc = m_epc;
    o.isr = m_isr;
    o.st  = 2'(m_mode);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = RST_PC; m_epc = 32'h0; m_isr = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                            input logic ir, input logic ret, input logic hlt);
    if (m_mode == M_BOOT || m_mode == M_INTE) begin
      m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (ir && !m_isr) begin
        m_epc = m_pc; m_pc = VEC; m_isr = 1'b1; m_mode = M_INTE;
      end
    end else if (!st) begin
      if (ret && m_isr) begin
        m_pc = m_epc; m_isr = 1'b0;
      end else if (ir && !m_isr) begin
        m_epc = br ? tgt : m_pc + STEP;
        m_pc = VEC; m_isr = 1'b1; m_mode = M_INTE;
      end else if (br) begin
        m_pc = tgt;
      end else if (hlt) begin
        m_pc = m_pc + STEP; m_mode = M_HALT;
      end else begin
        m_pc = m_pc + STEP;
      end
    end
  endtask

  // One clock cycle of stimulus; expected outputs for this cycle go to the scoreboard.
  task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] tgt,
                       input logic ir, input logic ret, input logic hlt);
    @(posedge clk);
    #1;
    reset = rst; stall = st; branchTaken = br; branchTarget = tgt;
    intReq = ir; retInt = ret; haltReq = hlt;
    if (rst) begin
      model_reset();
      exp_q.push_back(model_view());
    end else begin
      exp_q.push_back(model_view());
      model_step(st, br, tgt, ir, ret, hlt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{pc: pc, vld: pcValid, ack: intAck, epc: epc, isr: inIsr, st: state};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t got pc=%h vld=%b ack=%b epc=%h isr=%b st=%0d want pc=%h vld=%b ack=%b epc=%h isr=%b st=%0d",
                 $time, a.pc, a.vld, a.ack, a.epc, a.isr, a.st,
                 e.pc, e.vld, e.ack, e.epc, e.isr, e.st);
      end
    end
  end

  initial begin
    logic st, br, ret, hlt;
    logic [31:0] tgt;
    model_reset();
    pend = 1'b0;

    // Reset for 3 cycles, boot, sequential fetch.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Stall swallows a branch, then a real branch.
    cycle(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Interrupt entry, handler runs, nested request ignored, return.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Interrupt together with a branch saves the branch target.
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    // Halt, linger, then interrupt out of halt.
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    // 32-bit wrap of the sequential increment.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Async reset landing in the interrupt-entry cycle.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized phase; intReq is held as a level until the model enters INTE.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0 || (m_mode == M_HALT && m_isr && $urandom_range(0, 9) == 0)) begin
        pend = 1'b0;
        for (int r = 0; r < int'($urandom_range(1, 3)); r++)
          cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      end else begin
        if (!pend && $urandom_range(0, 11) == 0) pend = 1'b1;
        st  = ($urandom_range(0, 4) == 0);
        br  = ($urandom_range(0, 4) == 0);
        ret = ($urandom_range(0, 6) == 0);
        hlt = ($urandom_range(0, 24) == 0);
        tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : ($urandom() & 32'hFFFF_FFFE);
        cycle(1'b0, st, br, tgt, pend, ret, hlt);
        if (m_mode == M_INTE) pend = 1'b0;
      end
    end
    idle(1);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
